video_sync_prog: RTL
====================

Name: video_sync_prog

Overview:
Runtime-programmable video timing generator, the next generation of the fixed-parameter sync generator in the HDMI pipeline. It drives hsync/vsync/de and pixel coordinates to the framebuffer stage in the HDMI pixel-clock domain. Parameters set the reset-time mode. A shadowed config port allows mode changes, e.g. 1366x768 to 1280x720, without tearing. It adds programmable sync polarity, enable/restart, line/frame strobes, a frame counter and config validation.

Parameters:
async_reset, 1'b1, reset style selector; must be 1 for this block (async active-low).
H_BITS, 12, width of horizontal timing fields and o_x.
V_BITS, 11, width of vertical timing fields and o_y.
FCNT_BITS, 16, frame counter width.
H_ACTIVE / H_FRONT / H_SYNC / H_BACK, 1366 / 70 / 143 / 213, reset horizontal timing in pixels.
V_ACTIVE / V_FRONT / V_SYNC / V_BACK, 768 / 3 / 5 / 24, reset vertical timing in lines.
HS_POL / VS_POL, 1 / 1, reset sync active level.

Ports:
i_clk  in  1  pixel clock; all logic single-clock
i_nrst  in  1  reset, asynchronous, active-low
i_ena  in  1  run enable
i_cfg_wr  in  1  one-cycle strobe, captures cfg inputs
i_cfg_h_active, i_cfg_h_front, i_cfg_h_sync, i_cfg_h_back  in  H_BITS each  new horizontal timing
i_cfg_v_active, i_cfg_v_front, i_cfg_v_sync, i_cfg_v_back  in  V_BITS each  new vertical timing
i_cfg_hs_pol, i_cfg_vs_pol  in  1 each  new sync active levels
o_cfg_pending  out  1  valid config captured, not yet applied
o_cfg_err  out  1  one-cycle pulse: i_cfg_wr rejected
o_hsync  out  1  horizontal sync, active level = current hs_pol
o_vsync  out  1  vertical sync, active level = current vs_pol
o_de  out  1  data enable
o_x  out  H_BITS  pixel column in active area, else 0
o_y  out  V_BITS  line number in active area, else 0
o_line_start  out  1  pulse with first pixel (h=0) of every line
o_frame_start  out  1  pulse with pixel (0,0)
o_frame_cnt  out  FCNT_BITS  completed-frame counter

Behaviour:
- Reset (i_nrst=0, async):
  - Active set loads parameter defaults; pending cleared; counters h=0, v=0.
  - Outputs: o_de=0, o_x=0, o_y=0, o_hsync=~HS_POL, o_vsync=~VS_POL, strobes 0, o_frame_cnt=0, o_cfg_pending=0, o_cfg_err=0.
- Totals: HT = HA+HF+HS+HB, VT = VA+VF+VS+VB.
  - Compute in H_BITS+2 / V_BITS+2 bits.
  - Counter h runs 0..HT-1; v increments when h wraps and runs 0..VT-1.
- Regions per axis:
  - active [0, A)
  - front [A, A+F)
  - sync [A+F, A+F+S)
  - back to total
- de = h in active AND v in active.
- hsync is active while h is in the h sync region, on every line.
- vsync is active for all h while v is in the v sync region.
- Latency: all outputs are registered decodes of the counter state of the previous cycle (1 cycle). o_x/o_y equal h/v only while de.
- o_line_start=1 on the output cycle for h=0. o_frame_start=1 on the output cycle for h=0, v=0.
- o_frame_cnt increments (wrapping) on the cycle counters go from (HT-1, VT-1) to (0,0).
- Config capture:
  - i_cfg_wr=1 with a valid set copies the inputs to pending and sets o_cfg_pending.
  - A later write before the frame end overwrites pending (last wins).
- Config validity: every active and sync field nonzero, HT <= 2^H_BITS, VT <= 2^V_BITS. Front/back may be 0.
- Invalid write: o_cfg_err pulses the next cycle; pending and o_cfg_pending are unchanged.
- Apply: at the frame-end cycle (h=HT-1, v=VT-1, i_ena=1), pending is copied to active, o_cfg_pending clears, and counters wrap to (0,0). The first new-mode pixel appears at the output one cycle later.
- Simultaneous i_cfg_wr at the frame-end cycle:
  - The previously pending set (if any) is applied.
  - The new write becomes pending for the next frame end; o_cfg_pending stays 1.
- i_ena=0:
  - Counters are forced to (0,0).
  - Next-cycle outputs: o_de=0, syncs inactive at current polarity, strobes 0.
  - Any pending set is applied immediately; o_frame_cnt holds.
- Re-enable: the first enabled cycle produces (0,0), and o_frame_start fires one cycle later.
- Polarity change takes effect together with the timing at apply time. No glitch pulse is allowed: the sync output goes directly to the new inactive level.

Test Plan:
- Reset defaults, i_ena=1: hsync period 1792 clocks, active 143 clocks starting at h=1436. VT=800 lines. de high for 1366 clocks per line on 768 lines. o_frame_cnt=1 after 1,433,600 clocks.
- Write HA=4,HF=1,HS=2,HB=1, VA=3,VF=1,VS=1,VB=1, pols 0/0 mid-frame -> o_cfg_pending=1 until frame end. Then HT=8, VT=6: o_x sequence 0,1,2,3 then 0. hsync low at h=5..6. vsync low on line 4 only. o_frame_start every 48 clocks.
- Write with HS=0, then with HT=4097 -> o_cfg_err pulses 1 cycle each; pending and active timing unchanged.
- i_cfg_wr at exactly h=HT-1, v=VT-1 with an earlier write pending -> earlier set applied, new set pending, applied at the next frame end.
- Drop i_ena mid-line at h=2,v=1 for 3 cycles -> de=0, syncs inactive; on re-enable o_frame_start occurs 1 cycle later and o_frame_cnt is unchanged.
- Assert i_nrst=0 asynchronously mid-sync pulse -> outputs reach reset values without a clock edge, and defaults restored.

Source files
------------

// File: rtl/video_sync_prog.sv
// Programmable video timing generator. The timing/polarity config is shadowed and
// applied at frame end, or at once while disabled. All outputs are registered decodes.
module video_sync_prog #(
  parameter bit async_reset = 1'b1,
  parameter int H_BITS      = 12,
  parameter int V_BITS      = 11,
  parameter int FCNT_BITS   = 16,
  parameter int H_ACTIVE    = 1366,
  parameter int H_FRONT     = 70,
  parameter int H_SYNC      = 143,
  parameter int H_BACK      = 213,
  parameter int V_ACTIVE    = 768,
  parameter int V_FRONT     = 3,
  parameter int V_SYNC      = 5,
  parameter int V_BACK      = 24,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_ena,
  input  logic                 i_cfg_wr,
  input  logic [H_BITS-1:0]    i_cfg_h_active,
  input  logic [H_BITS-1:0]    i_cfg_h_front,
  input  logic [H_BITS-1:0]    i_cfg_h_sync,
  input  logic [H_BITS-1:0]    i_cfg_h_back,
  input  logic [V_BITS-1:0]    i_cfg_v_active,
  input  logic [V_BITS-1:0]    i_cfg_v_front,
  input  logic [V_BITS-1:0]    i_cfg_v_sync,
  input  logic [V_BITS-1:0]    i_cfg_v_back,
  input  logic                 i_cfg_hs_pol,
  input  logic                 i_cfg_vs_pol,
  output logic                 o_cfg_pending,
  output logic                 o_cfg_err,
  output logic                 o_hsync,
  output logic                 o_vsync,
  output logic                 o_de,
  output logic [H_BITS-1:0]    o_x,
  output logic [V_BITS-1:0]    o_y,
  output logic                 o_line_start,
  output logic                 o_frame_start,
  output logic [FCNT_BITS-1:0] o_frame_cnt
);
  localparam int HW = H_BITS + 2;
  localparam int VW = V_BITS + 2;

  typedef struct packed {
    logic [H_BITS-1:0] ha, hf, hs, hb;
    logic [V_BITS-1:0] va, vf, vs, vb;
    logic              hp, vp;
  } cfg_t;

  localparam cfg_t C_DEF = '{ha: H_BITS'(H_ACTIVE), hf: H_BITS'(H_FRONT),
                             hs: H_BITS'(H_SYNC),   hb: H_BITS'(H_BACK),
                             va: V_BITS'(V_ACTIVE), vf: V_BITS'(V_FRONT),
                             vs: V_BITS'(V_SYNC),   vb: V_BITS'(V_BACK),
                             hp: HS_POL,            vp: VS_POL};

  if (async_reset != 1'b1) begin : g_reset_style
    $error("video_sync_prog supports only async_reset = 1");
  end

  cfg_t                 r_act, r_pend;
  logic                 r_pend_vld, r_cfg_err;
  logic [H_BITS-1:0]    r_h, r_x;
  logic [V_BITS-1:0]    r_v, r_y;
  logic                 r_hsync, r_vsync, r_de, r_ls, r_fs;
  logic [FCNT_BITS-1:0] r_fcnt;

  cfg_t                 w_in, w_act_nx;
  logic [HW-1:0]        w_ht, w_in_ht, w_hs_lo, w_hs_hi;
  logic [VW-1:0]        w_vt, w_in_vt, w_vs_lo, w_vs_hi;
  logic                 w_in_ok, w_h_last, w_v_last, w_frame_end, w_apply;
  logic                 w_h_act, w_v_act, w_h_sync, w_v_sync, w_de;

  assign w_in = '{ha: i_cfg_h_active, hf: i_cfg_h_front, hs: i_cfg_h_sync, hb: i_cfg_h_back,
                  va: i_cfg_v_active, vf: i_cfg_v_front, vs: i_cfg_v_sync, vb: i_cfg_v_back,
                  hp: i_cfg_hs_pol,   vp: i_cfg_vs_pol};

  // Totals are two bits wider so a full 2^BITS line/frame and overflowing writes are both visible
  assign w_ht    = HW'(r_act.ha) + HW'(r_act.hf) + HW'(r_act.hs) + HW'(r_act.hb);
  assign w_vt    = VW'(r_act.va) + VW'(r_act.vf) + VW'(r_act.vs) + VW'(r_act.vb);
  assign w_in_ht = HW'(w_in.ha) + HW'(w_in.hf) + HW'(w_in.hs) + HW'(w_in.hb);
  assign w_in_vt = VW'(w_in.va) + VW'(w_in.vf) + VW'(w_in.vs) + VW'(w_in.vb);
  assign w_in_ok = (|w_in.ha) && (|w_in.hs) && (|w_in.va) && (|w_in.vs) &&
                   (w_in_ht <= HW'(2**H_BITS)) && (w_in_vt <= VW'(2**V_BITS));

  assign w_h_last    = HW'(r_h) == (w_ht - HW'(1));
  assign w_v_last    = VW'(r_v) == (w_vt - VW'(1));
  assign w_frame_end = i_ena && w_h_last && w_v_last;
  assign w_apply     = r_pend_vld && (w_frame_end || !i_ena);
  assign w_act_nx    = w_apply ? r_pend : r_act;

  assign w_hs_lo  = HW'(r_act.ha) + HW'(r_act.hf);
  assign w_hs_hi  = w_hs_lo + HW'(r_act.hs);
  assign w_vs_lo  = VW'(r_act.va) + VW'(r_act.vf);
  assign w_vs_hi  = w_vs_lo + VW'(r_act.vs);
  assign w_h_act  = r_h < r_act.ha;
  assign w_v_act  = r_v < r_act.va;
  assign w_h_sync = (HW'(r_h) >= w_hs_lo) && (HW'(r_h) < w_hs_hi);
  assign w_v_sync = (VW'(r_v) >= w_vs_lo) && (VW'(r_v) < w_vs_hi);
  assign w_de     = i_ena && w_h_act && w_v_act;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_act      <= C_DEF;
      r_pend     <= C_DEF;
      r_pend_vld <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_h        <= '0;
      r_v        <= '0;
      r_fcnt     <= '0;
      r_de       <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_hsync    <= ~HS_POL;
      r_vsync    <= ~VS_POL;
      r_ls       <= 1'b0;
      r_fs       <= 1'b0;
    end else begin
      r_act     <= w_act_nx;
      r_cfg_err <= i_cfg_wr && !w_in_ok;
      // A write landing on the apply cycle wins the shadow slot, so pending stays set
      if (i_cfg_wr && w_in_ok) begin
        r_pend     <= w_in;
        r_pend_vld <= 1'b1;
      end else if (w_apply) begin
        r_pend_vld <= 1'b0;
      end

      if (!i_ena) begin
        r_h <= '0;
        r_v <= '0;
      end else if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end

      if (w_frame_end) r_fcnt <= r_fcnt + 1'b1;

      r_de    <= w_de;
      r_x     <= w_de ? r_h : '0;
      r_y     <= w_de ? r_v : '0;
      // While disabled the syncs park at the inactive level of the config about to be active
      r_hsync <= i_ena ? (w_h_sync ? r_act.hp : ~r_act.hp) : ~w_act_nx.hp;
      r_vsync <= i_ena ? (w_v_sync ? r_act.vp : ~r_act.vp) : ~w_act_nx.vp;
      r_ls    <= i_ena && (r_h == '0);
      r_fs    <= i_ena && (r_h == '0) && (r_v == '0);
    end
  end

  assign o_cfg_pending = r_pend_vld;
  assign o_cfg_err     = r_cfg_err;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_de          = r_de;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_line_start  = r_ls;
  assign o_frame_start = r_fs;
  assign o_frame_cnt   = r_fcnt;
endmodule
